mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 17 +
 rtl/div_restore_step.sv | 27 ++
 rtl/mult_div_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   state_t      : FSM state encoding (IDLE, MULT, DIV, DONE)
//   ITER_DEFAULT : default iteration count (one bit per iteration)
//   ACC_W        : width of the full product / {hi,lo} result pair
package mult_div_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MULT = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int unsigned ITER_DEFAULT = 32;
   localparam int unsigned ACC_W        = 64;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes (purely combinational).
//   rem_in   : partial remainder, always < divisor
//   quo_in   : dividend bits still to be shifted in (MSB first), quotient bits at LSB
//   divisor  : divisor magnitude (non-zero)
//   rem_out  : partial remainder after this step
//   quo_out  : quo_in shifted left with the new quotient bit at bit 0
module div_restore_step (
   input  logic [31:0] rem_in,
   input  logic [31:0] quo_in,
   input  logic [31:0] divisor,
   output logic [31:0] rem_out,
   output logic [31:0] quo_out
);

   logic [32:0] shifted;
   logic        fits;

   always_comb begin
      shifted = {rem_in, quo_in[31]};
      fits    = (shifted >= {1'b0, divisor});
      // When the trial subtract fits, the result is below the divisor, so it
      // fits in 32 bits and the modulo-2^32 difference is exact.
      rem_out = fits ? (shifted[31:0] - divisor) : shifted[31:0];
      quo_out = {quo_in[30:0], fits};
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and signed divide (restoring
// on magnitudes), one iteration per clock.
//   clk, reset             : clock, synchronous active-high reset
//   start_mult, start_div  : one-cycle requests, accepted only in IDLE (mult wins)
//   a, b                   : operands, latched when a start is accepted
//   hi, lo                 : mult {hi,lo} = a*b; div lo = quotient, hi = remainder
//   busy                   : high while iterating
//   done                   : one-cycle completion pulse
//   div_zero               : last accepted divide had b == 0
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int unsigned ITER = ITER_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   localparam int unsigned      CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITER - 1);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [32:0]      acc_hi;   // Booth partial product (33b, sign-extended) or remainder
   logic [31:0]      acc_lo;   // Booth multiplier bits or dividend/quotient bits
   logic             booth_q;  // Booth q(-1) bit
   logic [32:0]      mcand;    // sign-extended multiplicand
   logic [31:0]      divisor;  // divisor magnitude
   logic             neg_q;
   logic             neg_r;

   logic [32:0]      booth_sum;
   logic [32:0]      booth_hi_next;
   logic [31:0]      booth_lo_next;
   logic [ACC_W-1:0] product;
   logic [31:0]      div_rem;
   logic [31:0]      div_quo;
   logic [31:0]      abs_a;
   logic [31:0]      abs_b;

   always_comb begin
      booth_sum = acc_hi;
      case ({acc_lo[0], booth_q})
         2'b01:   booth_sum = acc_hi + mcand;
         2'b10:   booth_sum = acc_hi - mcand;
         default: booth_sum = acc_hi;
      endcase
      // Arithmetic right shift of {sum, multiplier, q(-1)} by one.
      booth_hi_next = {booth_sum[32], booth_sum[32:1]};
      booth_lo_next = {booth_sum[0], acc_lo[31:1]};
      product       = {booth_hi_next[31:0], booth_lo_next};
      abs_a         = a[31] ? (32'd0 - a) : a;
      abs_b         = b[31] ? (32'd0 - b) : b;
   end

   div_restore_step u_div_step (
      .rem_in  (acc_hi[31:0]),
      .quo_in  (acc_lo),
      .divisor (divisor),
      .rem_out (div_rem),
      .quo_out (div_quo)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         count    <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         booth_q  <= 1'b0;
         mcand    <= '0;
         divisor  <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_mult) begin
                  count    <= '0;
                  div_zero <= 1'b0;
                  acc_hi   <= '0;
                  acc_lo   <= b;
                  booth_q  <= 1'b0;
                  mcand    <= {a[31], a};
                  busy     <= 1'b1;
                  state    <= S_MULT;
               end else if (start_div) begin
                  count   <= '0;
                  acc_hi  <= '0;
                  acc_lo  <= abs_a;
                  divisor <= abs_b;
                  neg_q   <= a[31] ^ b[31];
                  neg_r   <= a[31];
                  if (b == '0) begin
                     div_zero <= 1'b1;
                     done     <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     div_zero <= 1'b0;
                     busy     <= 1'b1;
                     state    <= S_DIV;
                  end
               end
            end
            S_MULT: begin
               acc_hi  <= booth_hi_next;
               acc_lo  <= booth_lo_next;
               booth_q <= acc_lo[0];
               count   <= count + CNT_W'(1);
               if (count == LAST) begin
                  hi    <= product[ACC_W-1:32];
                  lo    <= product[31:0];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DIV: begin
               acc_hi <= {1'b0, div_rem};
               acc_lo <= div_quo;
               count  <= count + CNT_W'(1);
               if (count == LAST) begin
                  lo    <= neg_q ? (32'd0 - div_quo) : div_quo;
                  hi    <= neg_r ? (32'd0 - div_rem) : div_rem;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
